// File: rtl/uart_rx_pkg.sv
// Shared receiver definitions: FSM state encoding and default framing parameters.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    SM_IDLE,
    SM_START,
    SM_DATA,
    SM_PARITY,
    SM_STOP,
    SM_WAIT_IDLE
  } state_e;

  localparam int unsigned DEF_DATA_BIT_COUNT   = 8;
  localparam int unsigned DEF_PARITY_BIT_COUNT = 0;
  localparam int unsigned DEF_PARITY_ODD       = 0;
  localparam int unsigned DEF_STOP_BIT_COUNT   = 1;
  localparam int unsigned DEF_CLK_PER_BIT      = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronised line, mid-bit sampling, one-cycle result pulses with error flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BIT_COUNT   = DEF_DATA_BIT_COUNT,
  parameter int unsigned PARITY_BIT_COUNT = DEF_PARITY_BIT_COUNT,
  parameter int unsigned PARITY_ODD       = DEF_PARITY_ODD,
  parameter int unsigned STOP_BIT_COUNT   = DEF_STOP_BIT_COUNT,
  parameter int unsigned CLK_PER_BIT      = DEF_CLK_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      serial,
  output logic [DATA_BIT_COUNT-1:0] data,
  output logic                      data_ready,
  output logic                      framing_error,
  output logic                      parity_error,
  output logic                      busy
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_COUNT = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BIT_COUNT - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BIT_COUNT - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  logic                      rx_s;
  state_e                    state;
  logic [CW-1:0]             clock_count;
  logic [3:0]                current_bit;
  logic [DATA_BIT_COUNT-1:0] shift_reg;
  logic                      parity_mismatch;
  logic                      expected_parity;

  uart_sync2 #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (serial),
    .q  (rx_s)
  );

  assign expected_parity = (^shift_reg) ^ ODD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= SM_IDLE;
      clock_count     <= '0;
      current_bit     <= '0;
      shift_reg       <= '0;
      parity_mismatch <= 1'b0;
      data            <= '0;
      data_ready      <= 1'b0;
      framing_error   <= 1'b0;
      parity_error    <= 1'b0;
      busy            <= 1'b0;
    end else begin
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      unique case (state)
        SM_IDLE: begin
          if (!rx_s) begin
            clock_count <= '0;
            busy        <= 1'b1;
            state       <= SM_START;
          end
        end
        SM_START: begin
          if (clock_count == HALF_COUNT) begin
            clock_count <= '0;
            if (rx_s) begin
              busy  <= 1'b0;
              state <= SM_IDLE;
            end else begin
              current_bit     <= '0;
              parity_mismatch <= 1'b0;
              state           <= SM_DATA;
            end
          end else begin
            clock_count <= clock_count + 1'b1;
          end
        end
        SM_DATA: begin
          if (clock_count == FULL_COUNT) begin
            clock_count <= '0;
            // Shift right so the first bit on the line ends up in the LSB.
            shift_reg   <= {rx_s, shift_reg[DATA_BIT_COUNT-1:1]};
            if (current_bit == LAST_DATA) begin
              current_bit <= '0;
              state       <= (PARITY_BIT_COUNT > 0) ? SM_PARITY : SM_STOP;
            end else begin
              current_bit <= current_bit + 4'd1;
            end
          end else begin
            clock_count <= clock_count + 1'b1;
          end
        end
        SM_PARITY: begin
          if (clock_count == FULL_COUNT) begin
            clock_count     <= '0;
            parity_mismatch <= rx_s ^ expected_parity;
            state           <= SM_STOP;
          end else begin
            clock_count <= clock_count + 1'b1;
          end
        end
        SM_STOP: begin
          if (clock_count == FULL_COUNT) begin
            clock_count <= '0;
            if (!rx_s) begin
              framing_error <= 1'b1;
              state         <= SM_WAIT_IDLE;
            end else if (current_bit == LAST_STOP) begin
              data         <= shift_reg;
              data_ready   <= 1'b1;
              parity_error <= parity_mismatch;
              busy         <= 1'b0;
              state        <= SM_IDLE;
            end else begin
              current_bit <= current_bit + 4'd1;
            end
          end else begin
            clock_count <= clock_count + 1'b1;
          end
        end
        SM_WAIT_IDLE: begin
          // A stuck-low line must not look like a fresh start bit.
          if (rx_s) begin
            busy  <= 1'b0;
            state <= SM_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= SM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 instance plus an 8E1 instance for parity checks.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial = 1'b1;
  logic       serial_p = 1'b1;
  logic [7:0] data, data_p;
  logic       data_ready, framing_error, parity_error, busy;
  logic       data_ready_p, framing_error_p, parity_error_p, busy_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int ready_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  int last_ready_cyc = 0, busy_rise_cyc = 0, busy_last_cyc = 0;
  int pready_cnt = 0, pfe_cnt = 0, ppe_cnt = 0;
  logic busy_prev = 1'b0;
  logic [7:0] ready_log [0:15];

  uart_rx #(
    .DATA_BIT_COUNT  (8),
    .PARITY_BIT_COUNT(0),
    .PARITY_ODD      (0),
    .STOP_BIT_COUNT  (1),
    .CLK_PER_BIT     (CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial       (serial),
    .data         (data),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  uart_rx #(
    .DATA_BIT_COUNT  (8),
    .PARITY_BIT_COUNT(1),
    .PARITY_ODD      (0),
    .STOP_BIT_COUNT  (1),
    .CLK_PER_BIT     (CPB)
  ) dut_p (
    .clk          (clk),
    .rst          (rst),
    .serial       (serial_p),
    .data         (data_p),
    .data_ready   (data_ready_p),
    .framing_error(framing_error_p),
    .parity_error (parity_error_p),
    .busy         (busy_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder; cyc at a negedge is the number of rising edges seen so far.
  always @(negedge clk) begin
    busy_prev <= busy;
    if (busy && !busy_prev) busy_rise_cyc <= cyc;
    if (busy) busy_last_cyc <= cyc;
    if (data_ready) begin
      ready_log[ready_cnt[3:0]] <= data;
      ready_cnt <= ready_cnt + 1;
      last_ready_cyc <= cyc;
    end
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (parity_error) pe_cnt <= pe_cnt + 1;
    if (data_ready_p) pready_cnt <= pready_cnt + 1;
    if (framing_error_p) pfe_cnt <= pfe_cnt + 1;
    if (parity_error_p) ppe_cnt <= ppe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit to_p, input logic v);
    if (to_p) serial_p = v;
    else serial = v;
    idle(CPB);
  endtask

  // Starts at a negedge; s is the cycle index of E0 (first edge seeing the start bit).
  task automatic send_frame(input bit to_p, input logic [7:0] d, input logic par,
                            input logic stop, output int s);
    s = cyc + 1;
    drive_bit(to_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_p, d[i]);
    if (to_p) drive_bit(to_p, par);
    drive_bit(to_p, stop);
  endtask

  initial begin
    int s, r0, f0;
    @(negedge clk);
    check("reset_data", {24'd0, data}, 32'h0);
    check("reset_pulses", {29'd0, data_ready, framing_error, parity_error}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    idle(2);
    rst = 1'b0;
    idle(4);

    // 8N1 0xA5 with exact timing.
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, s);
    idle(16);
    check("a5_count", ready_cnt, 1);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_ready_cyc", last_ready_cyc, s + 78);
    check("a5_busy_rise", busy_rise_cyc, s + 2);
    check("a5_busy_last", busy_last_cyc, s + 77);
    check("a5_no_fe", fe_cnt, 0);
    check("a5_no_pe", pe_cnt, 0);

    // Back-to-back frames, no idle gap between stop and next start.
    send_frame(1'b0, 8'h00, 1'b0, 1'b1, s);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, s);
    send_frame(1'b0, 8'h55, 1'b0, 1'b1, s);
    send_frame(1'b0, 8'h80, 1'b0, 1'b1, s);
    idle(16);
    check("b2b_count", ready_cnt, 5);
    check("b2b_d0", {24'd0, ready_log[1]}, 32'h00);
    check("b2b_d1", {24'd0, ready_log[2]}, 32'hFF);
    check("b2b_d2", {24'd0, ready_log[3]}, 32'h55);
    check("b2b_d3", {24'd0, ready_log[4]}, 32'h80);
    check("b2b_errs", fe_cnt + pe_cnt, 0);

    // 3-cycle glitch is rejected at the half-bit check.
    s = cyc + 1;
    serial = 1'b0;
    idle(3);
    serial = 1'b1;
    idle(24);
    check("glitch_count", ready_cnt, 5);
    check("glitch_busy_rise", busy_rise_cyc, s + 2);
    check("glitch_busy_last", busy_last_cyc, s + 5);
    check("glitch_busy_now", {31'd0, busy}, 32'h0);
    check("glitch_no_fe", fe_cnt, 0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, s);
    idle(16);
    check("3c_count", ready_cnt, 6);
    check("3c_data", {24'd0, data}, 32'h3C);

    // Low stop bit, then line stuck low for 40 bit-times.
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, s);
    idle(40 * CPB);
    check("fe_count", fe_cnt, 1);
    check("fe_no_ready", ready_cnt, 6);
    check("fe_data_held", {24'd0, data}, 32'h3C);
    check("fe_busy_stuck", {31'd0, busy}, 32'h1);
    serial = 1'b1;
    idle(2 * CPB);
    check("fe_busy_released", {31'd0, busy}, 32'h0);
    check("fe_no_retrigger", fe_cnt, 1);
    send_frame(1'b0, 8'h34, 1'b0, 1'b1, s);
    idle(16);
    check("34_count", ready_cnt, 7);
    check("34_data", {24'd0, data}, 32'h34);
    check("34_ready_cyc", last_ready_cyc, s + 78);

    // Even parity on 0x07: correct bit is 1.
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, s);
    idle(16);
    check("par_ok_ready", pready_cnt, 1);
    check("par_ok_pe", ppe_cnt, 0);
    send_frame(1'b1, 8'h07, 1'b0, 1'b1, s);
    idle(16);
    check("par_bad_ready", pready_cnt, 2);
    check("par_bad_pe", ppe_cnt, 1);
    check("par_bad_data", {24'd0, data_p}, 32'h07);
    check("par_no_fe", pfe_cnt, 0);

    // Reset in the middle of data bit 4.
    r0 = ready_cnt;
    f0 = fe_cnt;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
    serial = 1'b0;
    idle(CPB / 2);
    check("midrst_busy_before", {31'd0, busy}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_data", {24'd0, data}, 32'h0);
    check("midrst_busy", {31'd0, busy}, 32'h0);
    check("midrst_pulses", {29'd0, data_ready, framing_error, parity_error}, 32'h0);
    serial = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3 * CPB);
    check("midrst_no_pulse", ready_cnt + fe_cnt, r0 + f0);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b1, s);
    idle(16);
    check("c3_count", ready_cnt, r0 + 1);
    check("c3_data", {24'd0, data}, 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
